// File: rtl/ksa_if.sv
// Request/memory bus for the ARC4 key-scheduling stage: en/rdy handshake,
// key input and the single-port S memory port.
interface ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );

  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling permutation over a shared 256x8 S memory with a
// one-cycle synchronous read port. Four cycles per i, 1024 busy cycles per run.
module ksa (
  input  logic   clk,
  input  logic   rst_n,
  ksa_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD_I, CAP_I, CAP_J, WR_J} state_t;

  state_t      state, state_nx;
  logic [7:0]  i, j, si;
  logic [23:0] k;
  logic [1:0]  kc;   // i mod 3, stepped alongside i
  logic [7:0]  kb, jn;

  always_comb begin
    case (kc)
      2'd0:    kb = k[23:16];
      2'd1:    kb = k[15:8];
      default: kb = k[7:0];
    endcase
  end

  // rddata holds S[i] during CAP_I; the sum wraps at 8 bits
  assign jn = j + bus.rddata + kb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      k     <= 24'd0;
      kc    <= 2'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.en) begin
          k  <= bus.key;
          i  <= 8'd0;
          j  <= 8'd0;
          kc <= 2'd0;
        end
        CAP_I: begin
          si <= bus.rddata;
          j  <= jn;
        end
        WR_J: if (i != 8'hFF) begin
          i  <= i + 8'd1;
          kc <= (kc == 2'd2) ? 2'd0 : kc + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // CAP_J writes S[j] into slot i, WR_J writes old S[i] into slot j; when
  // i==j both writes land on the same slot with the same value.
  always_comb begin
    state_nx   = state;
    bus.rdy    = 1'b0;
    bus.addr   = 8'd0;
    bus.wrdata = 8'd0;
    bus.wren   = 1'b0;
    case (state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) state_nx = RD_I;
      end
      RD_I: begin
        bus.addr = i;
        state_nx = CAP_I;
      end
      CAP_I: begin
        bus.addr = jn;
        state_nx = CAP_J;
      end
      CAP_J: begin
        bus.addr   = i;
        bus.wrdata = bus.rddata;
        bus.wren   = 1'b1;
        state_nx   = WR_J;
      end
      WR_J: begin
        bus.addr   = j;
        bus.wrdata = si;
        bus.wren   = 1'b1;
        state_nx   = (i == 8'hFF) ? IDLE : RD_I;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
